bin_threshold_engine: RTL and testbench

Parametrised successor to the binarization stage. It runs after the grayscale stage has written a replicated-gray BMP into the shared dual-port RAM. It reads each pixel, compares it against a threshold, and writes back full-scale black or white to every byte of the pixel. The threshold is either a sampled port value or the image mean, computed in a preceding read-only pass, with optional output inversion. Header bytes are never touched.

---
 rtl/bin_threshold_engine_pkg.sv | 22 ++
 rtl/bin_mean_acc.sv | 32 +++
 rtl/bin_threshold_engine.sv | 187 ++++++++++++++++++
 tb/tb_bin_threshold_engine.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bin_threshold_engine_pkg.sv
// Shared definitions for the binarization engine: FSM encoding, default
// geometry and the bit positions inside the mode word.
package bin_threshold_engine_pkg;

  localparam int BYTE_WIDTH_DEF  = 8;
  localparam int ADDR_WIDTH_DEF  = 20;
  localparam int HEADER_SIZE_DEF = 54;

  localparam int MODE_INV_BIT  = 0;
  localparam int MODE_MEAN_BIT = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MEAN      = 3'd1,
    MEAN_LAST = 3'd2,
    RD        = 3'd3,
    CMP       = 3'd4,
    WR        = 3'd5,
    DONE      = 3'd6
  } state_e;

endpackage

// File: rtl/bin_mean_acc.sv
// Running sum of sampled gray bytes; mean_o is the sum divided by the pixel
// count (truncating). Wide enough that a full image cannot overflow it.
module bin_mean_acc #(
  parameter int BYTE_WIDTH  = 8,
  parameter int LOG2_PIXELS = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  add_i,
  input  logic [BYTE_WIDTH-1:0] din_i,
  output logic [BYTE_WIDTH-1:0] mean_o
);

  localparam int SUM_W = BYTE_WIDTH + LOG2_PIXELS;

  logic [SUM_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i)      sum_d = '0;
    else if (add_i) sum_d = sum_q + SUM_W'(din_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign mean_o = sum_q[SUM_W-1:LOG2_PIXELS];

endmodule

// File: rtl/bin_threshold_engine.sv
// In-place BMP binarization over a shared synchronous RAM.
// Define BIN_MEAN_EN to include the mean-threshold pre-pass (mode bit 1).
module bin_threshold_engine
  import bin_threshold_engine_pkg::*;
#(
  parameter int BYTE_WIDTH  = BYTE_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int HEADER_SIZE = HEADER_SIZE_DEF,
  parameter int PIXEL_BYTES = 3,
  parameter int LOG2_PIXELS = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  gray_done,
  input  logic [1:0]            mode,
  input  logic [BYTE_WIDTH-1:0] thr,
  input  logic [BYTE_WIDTH-1:0] RAM_out,
  output logic                  RAM_ren,
  output logic                  RAM_wen,
  output logic [BYTE_WIDTH-1:0] RAM_in,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic                  done
);

  localparam int                  BC_W      = $clog2(PIXEL_BYTES) + 1;
  localparam logic [BC_W-1:0]     LAST_BYTE = BC_W'(PIXEL_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] PIX_BASE = ADDR_WIDTH'(HEADER_SIZE);
  localparam logic [ADDR_WIDTH-1:0] PIX_STEP = ADDR_WIDTH'(PIXEL_BYTES);

  state_e                  state_q, state_d;
  logic [LOG2_PIXELS-1:0]  pix_q, pix_d;
  logic [BC_W-1:0]         byte_q, byte_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [BYTE_WIDTH-1:0]   thr_q, thr_d;
  logic [BYTE_WIDTH-1:0]   res_q, res_d;
  logic                    inv_q, inv_d;
  logic                    done_q, done_d;
  logic [BYTE_WIDTH-1:0]   thr_eff;

`ifdef BIN_MEAN_EN
  logic                  mean_sel_q, mean_sel_d;
  logic                  acc_clr, acc_add;
  logic [BYTE_WIDTH-1:0] acc_mean;

  bin_mean_acc #(
    .BYTE_WIDTH  (BYTE_WIDTH),
    .LOG2_PIXELS (LOG2_PIXELS)
  ) u_mean_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (acc_clr),
    .add_i  (acc_add),
    .din_i  (RAM_out),
    .mean_o (acc_mean)
  );

  // The sum is final by the first CMP, so the mean can be muxed in live.
  assign thr_eff = mean_sel_q ? acc_mean : thr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mean_sel_q <= 1'b0;
    else        mean_sel_q <= mean_sel_d;
  end
`else
  logic unused_mode;
  assign unused_mode = mode[MODE_MEAN_BIT];
  assign thr_eff     = thr_q;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can leave a latch behind.
    state_d  = state_q;
    pix_d    = pix_q;
    byte_d   = byte_q;
    base_d   = base_q;
    thr_d    = thr_q;
    res_d    = res_q;
    inv_d    = inv_q;
    done_d   = done_q;
    RAM_ren  = 1'b0;
    RAM_wen  = 1'b0;
    RAM_in   = '0;
    RAM_addr = '0;
`ifdef BIN_MEAN_EN
    mean_sel_d = mean_sel_q;
    acc_clr    = 1'b0;
    acc_add    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (in_valid && gray_done) begin
          thr_d  = thr;
          inv_d  = mode[MODE_INV_BIT];
          pix_d  = '0;
          byte_d = '0;
          base_d = PIX_BASE;
`ifdef BIN_MEAN_EN
          mean_sel_d = mode[MODE_MEAN_BIT];
          acc_clr    = 1'b1;
          state_d    = mode[MODE_MEAN_BIT] ? MEAN : RD;
`else
          state_d    = RD;
`endif
        end
      end
`ifdef BIN_MEAN_EN
      MEAN: begin
        RAM_ren  = 1'b1;
        RAM_addr = base_q;
        acc_add  = (pix_q != '0);  // first read has no data back yet
        base_d   = base_q + PIX_STEP;
        pix_d    = pix_q + LOG2_PIXELS'(1);
        if (pix_q == '1) state_d = MEAN_LAST;
      end
      MEAN_LAST: begin
        acc_add = 1'b1;
        base_d  = PIX_BASE;
        state_d = RD;
      end
`endif
      RD: begin
        RAM_ren  = 1'b1;
        RAM_addr = base_q;
        state_d  = CMP;
      end
      CMP: begin
        res_d   = {BYTE_WIDTH{RAM_out >= thr_eff}} ^ {BYTE_WIDTH{inv_q}};
        byte_d  = '0;
        state_d = WR;
      end
      WR: begin
        RAM_wen  = 1'b1;
        RAM_addr = base_q + ADDR_WIDTH'(byte_q);
        RAM_in   = res_q;
        if (byte_q == LAST_BYTE) begin
          byte_d  = '0;
          base_d  = base_q + PIX_STEP;
          pix_d   = pix_q + LOG2_PIXELS'(1);
          state_d = (pix_q == '1) ? DONE : RD;
        end else begin
          byte_d = byte_q + BC_W'(1);
        end
      end
      DONE: begin
        // done is shown for at least one cycle even if in_valid already fell.
        if (done_q && !in_valid) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    if (!rst_n) begin
      state_q <= IDLE;
      pix_q   <= '0;
      byte_q  <= '0;
      base_q  <= '0;
      thr_q   <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      byte_q  <= byte_d;
      base_q  <= base_d;
      thr_q   <= thr_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_bin_threshold_engine.sv
// Self-checking bench: two engines (3 and 4 bytes per pixel) share the control
// inputs, each with its own RAM; results are compared to an image-level model.
module tb_bin_threshold_engine;
  import bin_threshold_engine_pkg::*;

  localparam int N   = 16;
  localparam int HDR = 54;
`ifdef BIN_MEAN_EN
  localparam bit MEAN_EN = 1'b1;
`else
  localparam bit MEAN_EN = 1'b0;
`endif

  typedef logic [7:0] mem_t [0:127];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        gray_done = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  thr = 8'd0;

  logic        ren_a, wen_a, done_a, ren_b, wen_b, done_b;
  logic [7:0]  in_a, in_b, rdata_a, rdata_b;
  logic [19:0] addr_a, addr_b;

  mem_t mem_a, mem_b;
  int   total = 0;
  int   bad = 0;
  int   viol = 0;
  int   last_rd_a = 0;
  int   last_rd_b = 0;

  always #5 clk = ~clk;

  bin_threshold_engine #(.PIXEL_BYTES(3), .LOG2_PIXELS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gray_done(gray_done),
    .mode(mode), .thr(thr), .RAM_out(rdata_a), .RAM_ren(ren_a), .RAM_wen(wen_a),
    .RAM_in(in_a), .RAM_addr(addr_a), .done(done_a)
  );

  bin_threshold_engine #(.PIXEL_BYTES(4), .LOG2_PIXELS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gray_done(gray_done),
    .mode(mode), .thr(thr), .RAM_out(rdata_b), .RAM_ren(ren_b), .RAM_wen(wen_b),
    .RAM_in(in_b), .RAM_addr(addr_b), .done(done_b)
  );

  // Synchronous RAMs plus a protocol watcher on the strobes.
  always @(posedge clk) begin
    if (ren_a) begin rdata_a <= mem_a[addr_a[6:0]]; last_rd_a <= int'(addr_a); end
    if (wen_a) mem_a[addr_a[6:0]] <= in_a;
    if (ren_b) begin rdata_b <= mem_b[addr_b[6:0]]; last_rd_b <= int'(addr_b); end
    if (wen_b) mem_b[addr_b[6:0]] <= in_b;
    if ((ren_a && wen_a) || (ren_b && wen_b)) viol++;
    if (!ren_a && !wen_a && (in_a != 0 || addr_a != 0)) viol++;
    if (!ren_b && !wen_b && (in_b != 0 || addr_b != 0)) viol++;
    if ((ren_a || wen_a) && (addr_a < HDR || addr_a >= HDR + N*3)) viol++;
    if ((ren_b || wen_b) && (addr_b < HDR || addr_b >= HDR + N*4)) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input int pb, input logic [1:0] m);
    if (MEAN_EN && m[1]) return (N + 2) + N * (2 + pb);
    return N * (2 + pb) + 1;
  endfunction

  function automatic mem_t model(input mem_t orig, input int pb, input logic [1:0] m,
                                 input logic [7:0] t);
    mem_t r = orig;
    int   sum = 0;
    int   eff = int'(t);
    if (MEAN_EN && m[1]) begin
      for (int i = 0; i < N; i++) sum += int'(orig[HDR + i*pb]);
      eff = sum / N;
    end
    for (int i = 0; i < N; i++) begin
      logic [7:0] v;
      v = (int'(orig[HDR + i*pb]) >= eff) ? 8'hFF : 8'h00;
      if (m[0]) v = ~v;
      for (int b = 0; b < pb; b++) r[HDR + i*pb + b] = v;
    end
    return r;
  endfunction

  // kind: 0 alternating 127/128, 1 eight 10s then eight 50s,
  //       2 random gray, 3 alternating 254/255
  task automatic fill(input int kind);
    for (int k = 0; k < 128; k++) begin
      mem_a[k] = 8'($urandom);
      mem_b[k] = 8'($urandom);
    end
    for (int i = 0; i < N; i++) begin
      logic [7:0] g;
      case (kind)
        0:       g = (i % 2 == 0) ? 8'd127 : 8'd128;
        1:       g = (i < 8) ? 8'd10 : 8'd50;
        3:       g = (i % 2 == 0) ? 8'd254 : 8'd255;
        default: g = 8'($urandom);
      endcase
      for (int b = 0; b < 3; b++) mem_a[HDR + i*3 + b] = g;
      for (int b = 0; b < 4; b++) mem_b[HDR + i*4 + b] = g;
    end
  endtask

  task automatic cmp_image(input string tag, input mem_t got, input mem_t exp);
    int hdr_bad = 0;
    int pix_bad = 0;
    for (int k = 0; k < 128; k++) begin
      if (got[k] !== exp[k]) begin
        if (k < HDR) hdr_bad++;
        else         pix_bad++;
      end
    end
    check({tag, "_hdr"}, hdr_bad, 0);
    check({tag, "_pix"}, pix_bad, 0);
  endtask

  task automatic run_pass(input string tag, input logic [1:0] m, input logic [7:0] t,
                          input bit glitch);
    mem_t exp_a, exp_b;
    int   lat_a = 0;
    int   lat_b = 0;
    exp_a = model(mem_a, 3, m, t);
    exp_b = model(mem_b, 4, m, t);
    @(negedge clk);
    mode = m; thr = t; in_valid = 1'b1; gray_done = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 400 && (lat_a == 0 || lat_b == 0); k++) begin
      @(posedge clk); #1;
      if (glitch && k == 7) begin
        in_valid = 1'b0; gray_done = 1'b0; mode = ~m; thr = ~t;
      end
      if (done_a && lat_a == 0) lat_a = k;
      if (done_b && lat_b == 0) lat_b = k;
    end
    check({tag, "_lat_a"}, lat_a, exp_latency(3, m));
    check({tag, "_lat_b"}, lat_b, exp_latency(4, m));
    if (!glitch) begin
      repeat (3) begin
        @(posedge clk); #1;
        check({tag, "_hold"}, {done_a, done_b}, 2'b11);
      end
      @(negedge clk); in_valid = 1'b0; gray_done = 1'b0;
      @(posedge clk); #1;
      check({tag, "_drop"}, {done_a, done_b}, 2'b00);
    end else begin
      repeat (3) @(posedge clk);
      #1 check({tag, "_idle"}, {done_a, done_b}, 2'b00);
    end
    cmp_image({tag, "_a"}, mem_a, exp_a);
    cmp_image({tag, "_b"}, mem_b, exp_b);
  endtask

  initial begin
    bit found;
    int starts;
    mem_t exp_a;

    repeat (3) @(posedge clk);
    #1 check("rst_out_a", {ren_a, wen_a, in_a, addr_a, done_a}, 31'd0);
    check("rst_out_b", {ren_b, wen_b, in_b, addr_b, done_b}, 31'd0);
    @(negedge clk); rst_n = 1'b1;

    fill(0); run_pass("fix", 2'd0, 8'd128, 1'b0);
    check("last_rd_a", last_rd_a, HDR + 15*3);
    check("last_rd_b", last_rd_b, HDR + 15*4);
    fill(0); run_pass("inv", 2'd1, 8'd128, 1'b0);
    fill(1); run_pass("mean", 2'd2, 8'd60, 1'b0);
    fill(1); run_pass("mean_inv", 2'd3, 8'd60, 1'b0);
    fill(2); run_pass("thr0", 2'd0, 8'd0, 1'b0);
    fill(3); run_pass("thr255", 2'd0, 8'd255, 1'b0);
    for (int r = 0; r < 6; r++) begin
      fill(2);
      run_pass($sformatf("rnd%0d", r), 2'($urandom), 8'($urandom), r == 2);
    end

    // Start must wait for the upstream stage.
    starts = 0;
    @(negedge clk); in_valid = 1'b1; gray_done = 1'b0;
    repeat (5) begin @(posedge clk); #1 if (ren_a || ren_b) starts++; end
    check("no_start", starts, 0);
    @(negedge clk); in_valid = 1'b0;

    // Abort with reset while pixel 5 is being read.
    fill(2);
    @(negedge clk); mode = 2'd0; thr = 8'd100; in_valid = 1'b1; gray_done = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(posedge clk); #1;
      if (ren_a && addr_a == 20'(HDR + 5*3)) found = 1'b1;
    end
    check("p5_found", found, 1'b1);
    rst_n = 1'b0; in_valid = 1'b0; gray_done = 1'b0;
    #1 check("abort_out_a", {ren_a, wen_a, in_a, addr_a, done_a}, 31'd0);
    check("abort_out_b", {ren_b, wen_b, in_b, addr_b, done_b}, 31'd0);
    check("abort_st_a", 32'(dut_a.state_q), 32'(IDLE));
    check("abort_st_b", 32'(dut_b.state_q), 32'(IDLE));
    exp_a = model(mem_a, 3, 2'd0, 8'd100);
    check("abort_partial", (mem_a[HDR] == exp_a[HDR]) ? 1 : 0, 1);
    @(negedge clk); rst_n = 1'b1;
    run_pass("restart", 2'd2, 8'($urandom), 1'b0);

    check("protocol", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
